// File: rtl/shift_issue_stage.sv
// Issue stage feeding the execute-stage shift ALU: decodes RV32I shift fields and buffers
// them in a 2-entry skid buffer so in_ready never depends combinationally on out_ready.
module shift_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_func3,
  output logic [6:0]  out_func7,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic        out_is_shift,
  output logic        out_illegal
);

  localparam logic [6:0] OpReg  = 7'b0110011;
  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpJalr = 7'b1100111;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        is_shift;
    logic        illegal;
  } entry_t;

  entry_t dec;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept, pop;
  logic   is_i_type;

  always_comb begin
    dec          = '0;
    dec.opcode   = in_instr[6:0];
    dec.func3    = in_instr[14:12];
    dec.func7    = in_instr[31:25];
    dec.rd       = in_instr[11:7];
    dec.op1      = in_rs1_data;
    is_i_type    = (dec.opcode == OpImm) || (dec.opcode == OpLoad) || (dec.opcode == OpJalr);
    dec.imm      = is_i_type ? {{20{in_instr[31]}}, in_instr[31:20]} : 32'h0;
    dec.op2      = (dec.opcode == OpReg) ? in_rs2_data : dec.imm;
    dec.is_shift = ((dec.opcode == OpReg) || (dec.opcode == OpImm)) &&
                   ((dec.func3 == 3'b001) || (dec.func3 == 3'b101));
    // For I-type shifts imm[11:5] occupies the same bits as func7.
    dec.illegal  = dec.is_shift &&
                   !((dec.func7 == 7'b0000000) ||
                     ((dec.func3 == 3'b101) && (dec.func7 == 7'b0100000)));
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign pop      = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (accept) begin
            main_d       = dec;
            main_valid_d = 1'b1;
          end
        end
        2'b10: begin
          if (pop && accept) begin
            main_d = dec;
          end else if (pop) begin
            main_valid_d = 1'b0;
          end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
          end
        end
        2'b11: begin
          if (pop) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          // Skid without head is unreachable; recover to empty.
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_op1      = main_q.op1;
  assign out_op2      = main_q.op2;
  assign out_opcode   = main_q.opcode;
  assign out_func3    = main_q.func3;
  assign out_func7    = main_q.func7;
  assign out_imm      = main_q.imm;
  assign out_rd       = main_q.rd;
  assign out_is_shift = main_q.is_shift;
  assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: directed scenarios followed by random traffic.
module tb_shift_issue_stage;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_rs1_data, in_rs2_data;
  logic [31:0] out_op1, out_op2, out_imm;
  logic [6:0]  out_opcode, out_func7;
  logic [2:0]  out_func3;
  logic [4:0]  out_rd;
  logic        out_is_shift, out_illegal;
  logic [119:0] dut_bundle;
  logic [119:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  shift_issue_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_imm(out_imm), .out_rd(out_rd), .out_is_shift(out_is_shift),
    .out_illegal(out_illegal)
  );

  assign dut_bundle = {out_op1, out_op2, out_opcode, out_func3, out_func7, out_imm, out_rd,
                       out_is_shift, out_illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [119:0] model(input logic [31:0] ins, input logic [31:0] rs1,
                                          input logic [31:0] rs2);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] imm, op2;
    logic        sh, ill;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    imm = 32'h0;
    op2 = 32'h0;
    sh  = 1'b0;
    case (op)
      7'h33: begin op2 = rs2; sh = (f3 == 3'd1) || (f3 == 3'd5); end
      7'h13: begin
        imm = {{20{ins[31]}}, ins[31:20]};
        op2 = imm;
        sh  = (f3 == 3'd1) || (f3 == 3'd5);
      end
      7'h03, 7'h67: begin imm = {{20{ins[31]}}, ins[31:20]}; op2 = imm; end
      default: ;
    endcase
    ill = sh && (f7 != 7'h00) && !(f3 == 3'd5 && f7 == 7'h20);
    return {rs1, op2, op, f3, f7, imm, ins[11:7], sh, ill};
  endfunction

  // One cycle: score the pop and the accept seen at negedge, then advance to just past posedge.
  task automatic step();
    logic [119:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) check("sb_extra", 120'(1), 120'(0));
      else begin
        e = sb_q.pop_front();
        check("sb_order", dut_bundle, e);
      end
    end
    if (flush) sb_q.delete();
    else if (in_valid && in_ready) sb_q.push_back(model(in_instr, in_rs1_data, in_rs2_data));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs1,
                       input logic [31:0] rs2);
    in_valid    = v;
    in_instr    = ins;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
  endtask

  initial begin
    logic [6:0]  f7;
    logic [6:0]  op;
    logic [31:0] ins;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 120'(out_valid), 120'(0));
    check("rst_in_ready", 120'(in_ready), 120'(1));
    check("rst_payload", dut_bundle, 120'(0));

    // SLLI x5,x1,3
    out_ready = 1'b1;
    drive(1'b1, 32'h00309293, 32'h1, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("slli_valid", 120'(out_valid), 120'(1));
    check("slli_op2", 120'(out_op2), 120'(32'd3));
    check("slli_is_shift", 120'(out_is_shift), 120'(1));
    check("slli_illegal", 120'(out_illegal), 120'(0));
    check("slli_rd", 120'(out_rd), 120'(5'd5));

    // SRAI legal then SRAI with imm[11:5]=0100001
    drive(1'b1, 32'h4030D293, 32'h80000000, 32'h0);
    step();
    check("srai_legal", 120'(out_illegal), 120'(0));
    drive(1'b1, 32'h4230D293, 32'h80000000, 32'h0);
    step();
    check("srai_bad_illegal", 120'(out_illegal), 120'(1));
    check("srai_bad_shift", 120'(out_is_shift), 120'(1));

    // SRA x5,x1,x2
    drive(1'b1, 32'h4020D2B3, 32'h12345678, 32'hFFFFFFE4);
    step();
    check("sra_op2", 120'(out_op2), 120'(32'hFFFFFFE4));
    check("sra_imm", 120'(out_imm), 120'(0));
    check("sra_func7", 120'(out_func7), 120'(7'h20));
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    step();

    // A,B,C stream with a stall once A is at head
    drive(1'b1, 32'h00309293, 32'hA, 32'h0);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'h0030D293, 32'hB, 32'h0);
    step();
    check("skid_in_ready", 120'(in_ready), 120'(0));
    check("skid_head_a", 120'(out_op1), 120'(32'hA));
    drive(1'b1, 32'h4030D293, 32'hC, 32'h0);
    step();
    step();
    check("full_hold_valid", 120'(out_valid), 120'(1));
    check("full_hold_head", 120'(out_op1), 120'(32'hA));
    out_ready = 1'b1;
    step();
    check("release_in_ready", 120'(in_ready), 120'(1));
    check("release_head_b", 120'(out_op1), 120'(32'hB));
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("release_head_c", 120'(out_op1), 120'(32'hC));
    step();
    check("stream_drain", 120'(sb_q.size()), 120'(0));
    check("stream_empty", 120'(out_valid), 120'(0));

    // Flush while FULL with a valid input
    out_ready = 1'b0;
    drive(1'b1, 32'h00209113, 32'hD, 32'h0);
    step();
    drive(1'b1, 32'h00409113, 32'hE, 32'h0);
    step();
    check("pre_flush_full", 120'(in_ready), 120'(0));
    drive(1'b1, 32'h00509113, 32'hF, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("flush_valid", 120'(out_valid), 120'(0));
    check("flush_in_ready", 120'(in_ready), 120'(1));
    out_ready = 1'b1;
    repeat (3) step();

    // Async reset in HALF
    out_ready = 1'b0;
    drive(1'b1, 32'h00309293, 32'h77, 32'h5);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    check("half_valid", 120'(out_valid), 120'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 120'(out_valid), 120'(0));
    check("arst_in_ready", 120'(in_ready), 120'(1));
    check("arst_payload", dut_bundle, 120'(0));
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: op = 7'h33;
        1, 2: op = 7'h13;
        3: op = 7'h03;
        default: op = 7'h37;
      endcase
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      ins = {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), op};
      drive(1'($urandom_range(0, 1)), ins, $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (3) step();
    check("rand_drain", 120'(sb_q.size()), 120'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Registered issue stage on the driving side of the execute-stage shift ALU. Accepts a raw instruction with its register-file operands through a valid/ready handshake and decodes the shift fields: opcode, func3, func7, immediate, operand 2 and shift legality. Presents them to the ALU through a 2-entry skid buffer. This decouples decode from execute stalls without a combinational ready path, and supports a pipeline flush.

## Interface
- No parameters; all widths fixed (RV32I).
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all buffered entries and the same-cycle input
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; registered, equals !skid_valid
- in_instr  input  32  raw instruction word
- in_rs1_data  input  32  rs1 value
- in_rs2_data  input  32  rs2 value
- out_valid  output  1  head entry valid
- out_ready  input  1  ALU consumes head this cycle
- out_op1  output  32  rs1 value
- out_op2  output  32  rs2 for R-type, sign-extended immediate otherwise
- out_opcode  output  7  instr[6:0]
- out_func3  output  3  instr[14:12]
- out_func7  output  7  instr[31:25]
- out_imm  output  32  sign-extended instr[31:20] for I-type; 0 otherwise
- out_rd  output  5  instr[11:7]
- out_is_shift  output  1  SLL/SRL/SRA or SLLI/SRLI/SRAI
- out_illegal  output  1  shift encoding with an invalid func7 or imm[11:5]

## Operation
- Decode is combinational on in_instr. The decoded bundle is captured only on the handshake (in_valid & in_ready & !flush).
- is_shift: opcode 0110011 (R) or 0010011 (I) with func3 001 or 101.
- Legality:
  - func3 001: func7 (R) or imm[11:5] (I) must be 0000000.
  - func3 101: it must be 0000000 (logical) or 0100000 (arithmetic).
  - Anything else sets out_illegal=1; out_is_shift stays 1.
- Non-shift instructions pass through with out_is_shift=0 and out_illegal=0.
- Storage: main register (head, drives out_*) and skid register.
- State is the pair (main_valid, skid_valid):
  - EMPTY (0,0): accept goes to main; becomes HALF.
  - HALF (1,0):
    - pop with no accept: EMPTY.
    - pop with accept: new entry goes to main; stays HALF.
    - accept with no pop: new entry goes to skid; becomes FULL.
    - neither: stays HALF.
  - FULL (1,1): in_ready=0, so no accept. Pop moves skid to main and becomes HALF.
- Order is preserved. A new entry never overtakes the skid entry.
- Flush has priority over everything. At the next edge both valids are 0, the same-cycle input is dropped, and the same-cycle pop is still considered consumed. in_ready is 1 in the cycle after a flush.
- Payload registers update only on capture or skid-to-main move. When invalid, out_* hold their last value except out_valid.

## Timing
- Reset (async assert; deassert synchronous to clk):
  - out_valid=0, in_ready=1.
  - All out_* data, out_is_shift and out_illegal are 0.
  - Both entry valids are 0.
- Latency: accept at edge N gives out_valid=1 with payload in the cycle after edge N (1 cycle).
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready depends only on registers and has no combinational path from out_ready.
- After out_ready deasserts, one more entry can be accepted (into skid). in_ready drops the following cycle.
- Reset mid-operation drops all entries immediately. There is no partial-state retention.

## Test plan
- Reset, then SLLI x5,x1,3 (instr 0x00309293), rs1=0x1 -> next cycle out_valid=1, out_op2=3, out_is_shift=1, out_illegal=0, out_rd=5.
- SRAI with imm[11:5]=0100000 (0x4030D293), then SRAI with imm[11:5]=0100001 -> first out_illegal=0; second out_illegal=1, out_is_shift=1.
- R-type SRA (func7 0100000), rs2=0xFFFFFFE4 -> out_op2=0xFFFFFFE4, out_imm=0, out_func7=0x20.
- Back-to-back stream A,B,C with out_ready=0 starting when A is at head -> B captured into skid; in_ready=0 next cycle; C held upstream. On release, output order is A,B,C with no loss or duplication.
- In FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears at the output.
- Assert rst asynchronously mid-clock while HALF -> out_valid falls without a clock edge, in_ready=1, and outputs are 0.
